core_inst_seq: RTL and testbench

Autonomous instruction sequencer for the attention core. It replaces host cycle-by-cycle driving of the 18-bit inst bus: on one start pulse it runs K load, Q execute, ofifo→pmem drain, and per-vector norm/write-back. In IDLE the host still owns inst and uses it for qmem/kmem writes. Sits between host/top-level and core.inst.

---
 rtl/core_pkg.sv | 36 +++
 rtl/seq_cnt.sv | 40 ++++
 rtl/core_inst_seq.sv | 197 +++++++++++++++++++
 tb/tb_core_inst_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared inst field positions and sequencer state encoding
package core_pkg;

   localparam int INST_W = 18;

   localparam int NORM_B      = 17;
   localparam int OFIFO_RD_B  = 16;
   localparam int QK_ADD_LSB  = 12;
   localparam int P_ADD_LSB   = 8;
   localparam int EXECUTE_B   = 7;
   localparam int LOAD_B      = 6;
   localparam int QMEM_RD_B   = 5;
   localparam int QMEM_WR_B   = 4;
   localparam int KMEM_RD_B   = 3;
   localparam int KMEM_WR_B   = 2;
   localparam int PMEM_RD_B   = 1;
   localparam int PMEM_WR_B   = 0;

   typedef enum logic [3:0] {
      IDLE,
      KLOAD,
      KFLUSH1,
      KFLUSH2,
      GAP1,
      EXEC,
      EXEC_END,
      WAIT_OF,
      DRAIN,
      DRAIN_END,
      NORM_RD,
      NORM_DIV,
      NORM_WB,
      DONE
   } seq_state_t;

endpackage

// File: rtl/seq_cnt.sv
// rtl/seq_cnt.sv - loadable up-counter exposing its next value and a terminal-count flag
module seq_cnt #(
   parameter int W  = 5,
   parameter int IW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [W-1:0]  load_val,
   input  logic          en,
   input  logic [W-1:0]  term,
   output logic [IW-1:0] idx_nxt,
   output logic          tc
);

   logic [W-1:0] count;
   logic [W-1:0] count_nxt;

   always_comb begin
      count_nxt = count;
      if (load) begin
         count_nxt = load_val;
      end else if (en) begin
         count_nxt = count + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

   // idx_nxt lets the owner register outputs aligned with the state they belong to
   assign idx_nxt = count_nxt[IW-1:0];
   assign tc      = (count == term);

endmodule

// File: rtl/core_inst_seq.sv
// rtl/core_inst_seq.sv - autonomous K-load / Q-exec / drain / norm sequencer driving core.inst
module core_inst_seq
   import core_pkg::*;
#(
   parameter int col        = 8,
   parameter int addr_bw    = 4,
   parameter int gap_cycles = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [addr_bw-1:0] cfg_nq,
   input  logic [INST_W-1:0]  host_inst,
   input  logic               ofifo_valid,
   output logic [INST_W-1:0]  inst,
   output logic               busy,
   output logic               done,
   output logic [3:0]         phase
);

   localparam int CW = addr_bw + 1;

   seq_state_t         state;
   seq_state_t         next_state;
   logic [CW-1:0]      nq_m1;
   logic [CW-1:0]      p_term;
   logic               p_load;
   logic               p_en;
   logic               p_tc;
   logic [addr_bw-1:0] p_idx;
   logic               v_load;
   logic               v_en;
   logic               v_tc;
   logic [addr_bw-1:0] v_idx;
   logic [addr_bw-1:0] k_addr;
   logic [INST_W-1:0]  next_inst;

   seq_cnt #(.W(CW), .IW(addr_bw)) u_phase_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (p_load),
      .load_val ('0),
      .en       (p_en),
      .term     (p_term),
      .idx_nxt  (p_idx),
      .tc       (p_tc)
   );

   seq_cnt #(.W(CW), .IW(addr_bw)) u_vec_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (v_load),
      .load_val ('0),
      .en       (v_en),
      .term     (nq_m1),
      .idx_nxt  (v_idx),
      .tc       (v_tc)
   );

   always_comb begin
      next_state = state;
      p_load     = 1'b0;
      p_en       = 1'b0;
      p_term     = '0;
      v_load     = 1'b0;
      v_en       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = KLOAD;
               p_load     = 1'b1;
            end
         end
         KLOAD: begin
            p_term = CW'(col);
            if (p_tc) next_state = KFLUSH1;
            else      p_en = 1'b1;
         end
         KFLUSH1: next_state = KFLUSH2;
         KFLUSH2: begin
            next_state = GAP1;
            p_load     = 1'b1;
         end
         GAP1: begin
            p_term = CW'(gap_cycles - 1);
            if (p_tc) begin
               next_state = EXEC;
               p_load     = 1'b1;
            end else begin
               p_en = 1'b1;
            end
         end
         EXEC: begin
            p_term = nq_m1;
            if (p_tc) next_state = EXEC_END;
            else      p_en = 1'b1;
         end
         EXEC_END: begin
            next_state = WAIT_OF;
            p_load     = 1'b1;
         end
         // counter saturates at the minimum wait, then only ofifo_valid releases
         WAIT_OF: begin
            p_term = CW'(gap_cycles - 1);
            if (!p_tc) begin
               p_en = 1'b1;
            end else if (ofifo_valid) begin
               next_state = DRAIN;
               p_load     = 1'b1;
            end
         end
         DRAIN: begin
            p_term = nq_m1;
            if (p_tc) next_state = DRAIN_END;
            else      p_en = 1'b1;
         end
         DRAIN_END: begin
            next_state = NORM_RD;
            v_load     = 1'b1;
         end
         NORM_RD:  next_state = NORM_DIV;
         NORM_DIV: next_state = NORM_WB;
         NORM_WB: begin
            if (v_tc) begin
               next_state = DONE;
            end else begin
               next_state = NORM_RD;
               v_en       = 1'b1;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // encode from the next state so inst lines up with phase after the clock edge
   always_comb begin
      next_inst = '0;
      k_addr    = p_idx - addr_bw'(1);
      case (next_state)
         IDLE: next_inst = host_inst;
         KLOAD: begin
            next_inst[LOAD_B] = 1'b1;
            if (p_idx != '0) begin
               next_inst[KMEM_RD_B]                 = 1'b1;
               next_inst[QK_ADD_LSB +: addr_bw]     = k_addr;
            end
         end
         KFLUSH1: next_inst[LOAD_B] = 1'b1;
         EXEC: begin
            next_inst[EXECUTE_B]                 = 1'b1;
            next_inst[QMEM_RD_B]                 = 1'b1;
            next_inst[QK_ADD_LSB +: addr_bw]     = p_idx;
         end
         DRAIN: begin
            next_inst[OFIFO_RD_B]                = 1'b1;
            next_inst[PMEM_WR_B]                 = 1'b1;
            next_inst[P_ADD_LSB +: addr_bw]      = p_idx;
         end
         NORM_RD: begin
            next_inst[PMEM_RD_B]                 = 1'b1;
            next_inst[P_ADD_LSB +: addr_bw]      = v_idx;
         end
         NORM_DIV: begin
            next_inst[NORM_B]                    = 1'b1;
            next_inst[P_ADD_LSB +: addr_bw]      = v_idx;
         end
         NORM_WB: begin
            next_inst[NORM_B]                    = 1'b1;
            next_inst[PMEM_WR_B]                 = 1'b1;
            next_inst[P_ADD_LSB +: addr_bw]      = v_idx;
         end
         default: next_inst = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         inst  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         nq_m1 <= '0;
      end else begin
         state <= next_state;
         inst  <= next_inst;
         busy  <= !(next_state inside {IDLE, DONE});
         done  <= (next_state == DONE);
         if (state == IDLE && start) begin
            nq_m1 <= {1'b0, cfg_nq};
         end
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_core_inst_seq.sv
// tb/tb_core_inst_seq.sv - scoreboard bench for core_inst_seq against a per-cycle run model
module tb_core_inst_seq;

   localparam int COL = 8;
   localparam int GAP = 10;

   localparam int B_NORM = 17, B_OFR = 16, B_EX = 7, B_LD = 6;
   localparam int B_QR = 5, B_QW = 4, B_KR = 3, B_KW = 2, B_PR = 1, B_PW = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  cfg_nq;
   logic [17:0] host_inst;
   logic        ofifo_valid;
   logic [17:0] inst;
   logic        busy;
   logic        done;
   logic [3:0]  phase;

   core_inst_seq #(.col(COL), .addr_bw(4), .gap_cycles(GAP)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cfg_nq      (cfg_nq),
      .host_inst   (host_inst),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done),
      .phase       (phase)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [17:0] inst;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t        exp_q[$];
   logic [17:0] pt_q[$];
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
   endtask

   function automatic logic [17:0] bv(input int b);
      logic [17:0] r;
      r    = '0;
      r[b] = 1'b1;
      return r;
   endfunction

   function automatic logic [17:0] qa(input int a);
      logic [17:0] r;
      r        = '0;
      r[15:12] = a[3:0];
      return r;
   endfunction

   function automatic logic [17:0] pa(input int a);
      logic [17:0] r;
      r       = '0;
      r[11:8] = a[3:0];
      return r;
   endfunction

   function automatic logic [17:0] legal_host();
      logic [17:0] r;
      r = 18'($urandom);
      if (r[B_QR]) r[B_QW] = 1'b0;
      if (r[B_KR]) r[B_KW] = 1'b0;
      if (r[B_PR]) r[B_PW] = 1'b0;
      if (r[B_EX]) r[B_LD] = 1'b0;
      return r;
   endfunction

   // monitor: invariants every cycle, run trace while busy/done, passthrough otherwise
   initial begin
      exp_t        e;
      logic [17:0] p;
      forever begin
         @(posedge clk);
         #1;
         chk("invariant", {28'd0, inst[B_QR] & inst[B_QW], inst[B_KR] & inst[B_KW],
                           inst[B_PR] & inst[B_PW], inst[B_EX] & inst[B_LD]}, 32'd0);
         if (busy || done) begin
            if (exp_q.size() == 0) begin
               chk("spurious_output", {12'd0, inst, busy, done}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("run_cycle", {12'd0, inst, busy, done}, {12'd0, e});
            end
         end else if (pt_q.size() != 0) begin
            p = pt_q.pop_front();
            chk("passthrough", {14'd0, inst}, {14'd0, p});
         end
      end
   end

   task automatic run(input int nq_m1, input int t_of, input int abort_at);
      exp_t tr[$];
      exp_t e;
      int   nq, wstart, wlen, len;
      nq     = nq_m1 + 1;
      wstart = COL + 3 + GAP + nq + 2;
      wlen   = (t_of - wstart + 1 > GAP) ? (t_of - wstart + 1) : GAP;
      e.busy = 1'b1;
      e.done = 1'b0;
      for (int c = 0; c <= COL; c++) begin
         e.inst = bv(B_LD) | ((c > 0) ? (bv(B_KR) | qa(c - 1)) : 18'd0);
         tr.push_back(e);
      end
      e.inst = bv(B_LD);
      tr.push_back(e);
      e.inst = '0;
      repeat (1 + GAP) tr.push_back(e);
      for (int i = 0; i < nq; i++) begin
         e.inst = bv(B_EX) | bv(B_QR) | qa(i);
         tr.push_back(e);
      end
      e.inst = '0;
      repeat (1 + wlen) tr.push_back(e);
      for (int i = 0; i < nq; i++) begin
         e.inst = bv(B_OFR) | bv(B_PW) | pa(i);
         tr.push_back(e);
      end
      e.inst = '0;
      tr.push_back(e);
      for (int v = 0; v < nq; v++) begin
         e.inst = bv(B_PR) | pa(v);
         tr.push_back(e);
         e.inst = bv(B_NORM) | pa(v);
         tr.push_back(e);
         e.inst = bv(B_NORM) | bv(B_PW) | pa(v);
         tr.push_back(e);
      end
      e.inst = '0;
      e.busy = 1'b0;
      e.done = 1'b1;
      tr.push_back(e);
      len = tr.size();
      if (abort_at > 0) begin
         while (tr.size() > abort_at) void'(tr.pop_back());
      end

      @(negedge clk);
      foreach (tr[j]) exp_q.push_back(tr[j]);
      start       = 1'b1;
      cfg_nq      = 4'(nq_m1);
      host_inst   = legal_host();
      ofifo_valid = (t_of <= 0);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         start       = ($urandom_range(0, 3) == 0);
         cfg_nq      = 4'($urandom);
         host_inst   = legal_host();
         ofifo_valid = (k >= t_of);
         if (k == abort_at) begin
            start = 1'b0;
            reset = 1'b1;
            pt_q.push_back('0);
            break;
         end
      end
      @(negedge clk);
      reset     = 1'b0;
      start     = 1'b0;
      host_inst = '0;
      pt_q.push_back('0);
      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("phase_idle", 32'(phase), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int n, t;
      reset       = 1'b1;
      start       = 1'b0;
      cfg_nq      = '0;
      host_inst   = '0;
      ofifo_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_inst", 32'(inst), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_phase", 32'(phase), 32'd0);

      reset     = 1'b0;
      host_inst = 18'h00010;
      pt_q.push_back(18'h00010);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         host_inst = bv(B_QW) | qa(i);
         pt_q.push_back(host_inst);
      end
      repeat (20) begin
         @(negedge clk);
         host_inst = legal_host();
         pt_q.push_back(host_inst);
      end
      @(negedge clk);
      host_inst = '0;
      pt_q.push_back('0);

      run(7, 0, 0);
      run(7, COL + 3 + GAP + 8 + 2 + 30, 0);
      run(0, 0, 0);
      run(15, 0, 0);
      run(7, 0, COL + 3 + GAP + 8 + 1 + GAP + 4);
      run(7, 0, 0);
      repeat (4) begin
         n = $urandom_range(0, 15);
         t = ($urandom_range(0, 1) == 1) ? 0 : (COL + GAP + n + 6 + $urandom_range(0, 25));
         run(n, t, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
